// File: rtl/pending_enc_pkg.sv
// Shared definitions for the pending-event encoder: line count, index width,
// FSM state encoding and a one-hot helper.
package pending_enc_pkg;

    localparam int unsigned N_LINES = 8;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // One-hot mask with the bit at position idx set.
    function automatic logic [N_LINES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return N_LINES'(1) << idx;
    endfunction

endpackage

// File: rtl/prio_pick8.sv
// Combinational selector over eight request lines.
// rr=0: highest set index wins. rr=1: first set index found searching upward
// from start, wrapping from 7 back to 0.
module prio_pick8
    import pending_enc_pkg::*;
(
    input  logic [N_LINES-1:0] req,
    input  logic [IDX_W-1:0]   start,
    input  logic               rr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic             found;
    logic [IDX_W-1:0] pos;

    // Pick one set request line according to the selected policy.
    always_comb begin
        idx   = '0;
        any   = |req;
        found = 1'b0;
        pos   = '0;
        if (!rr) begin
            // Ascending scan; the last hit is the highest set index.
            for (int unsigned i = 0; i < N_LINES; i++) begin
                if (req[i]) begin
                    idx = IDX_W'(i);
                end
            end
        end else begin
            for (int unsigned off = 0; off < N_LINES; off++) begin
                pos = IDX_W'(32'(start) + off);
                if (!found && req[pos]) begin
                    idx   = pos;
                    found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pending_encoder8to3.sv
// Pending-event encoder: latches event lines into a pending bitmap and
// presents one pending index at a time to a ready/valid consumer.
// Holds the pending register, the IDLE/PRESENT FSM, last_grant and overflow.
module pending_encoder8to3
    import pending_enc_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_LINES-1:0]  A,
    input  logic                clr_all,
    input  logic                ready,
    output logic [IDX_W-1:0]    Y,
    output logic                valid,
    output logic [N_LINES-1:0]  pending,
    output logic                overflow
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   y_q, y_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;

    logic               xfer;
    logic [N_LINES-1:0] pop_mask;
    logic [N_LINES-1:0] remain;
    logic [IDX_W-1:0]   pick_start;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    prio_pick8 u_pick (
        .req   (remain),
        .start (pick_start),
        .rr    (ROUND_ROBIN),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Transfer detection, pending update, overflow and last_grant next values.
    always_comb begin
        xfer     = (state_q == PRESENT) && ready;
        pop_mask = xfer ? idx_onehot(y_q) : '0;
        remain   = pending_q & ~pop_mask;
        // On a transfer edge the grant being made is y_q, so the rotation
        // continues from just past it rather than from the stale last_grant.
        pick_start   = xfer ? (y_q + IDX_W'(1)) : (last_grant_q + IDX_W'(1));
        pending_d    = clr_all ? '0 : (remain | A);
        ovf_d        = !clr_all && (|(A & remain));
        last_grant_d = (xfer && !clr_all) ? y_q : last_grant_q;
    end

    // FSM next state and presented index.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        if (clr_all) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_d = PRESENT;
                        y_d     = pick_idx;
                    end
                end
                PRESENT: begin
                    if (ready) begin
                        if (pick_any) begin
                            y_d = pick_idx;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and presented-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
        end
    end

    // Pending bitmap, overflow pulse and rotation pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q    <= '0;
            ovf_q        <= 1'b0;
            last_grant_q <= '1;
        end else begin
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Drive outputs from registered state.
    always_comb begin
        valid    = (state_q == PRESENT);
        Y        = y_q;
        pending  = pending_q;
        overflow = ovf_q;
    end

endmodule

// File: tb/tb_pending_encoder8to3.sv
// Self-checking bench for pending_encoder8to3: one fixed-priority and one
// round-robin instance share the inputs; expectations flow through a queue.
module tb_pending_encoder8to3;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic       clr_all;
    logic       ready;

    logic [2:0] y_fp, y_rr;
    logic       v_fp, v_rr;
    logic [7:0] p_fp, p_rr;
    logic       o_fp, o_rr;

    int n_checks = 0;
    int n_fail   = 0;

    pending_encoder8to3 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .A(A), .clr_all(clr_all), .ready(ready),
        .Y(y_fp), .valid(v_fp), .pending(p_fp), .overflow(o_fp)
    );

    pending_encoder8to3 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .A(A), .clr_all(clr_all), .ready(ready),
        .Y(y_rr), .valid(v_rr), .pending(p_rr), .overflow(o_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic       clr;
        logic       rdy;
        int         sel;
        logic [2:0] y;
        logic       v;
        logic [7:0] p;
        logic       o;
    } vec_t;

    typedef struct {
        int         sel;
        logic [2:0] y;
        logic       v;
        logic [7:0] p;
        logic       o;
        string      tag;
    } exp_t;

    exp_t sb[$];
    vec_t fp_tab[$];
    vec_t rr_tab[$];

    // Reference model state, index 0 = fixed priority, 1 = round robin.
    logic       m_v[2];
    logic [2:0] m_y[2];
    logic [7:0] m_p[2];
    logic       m_o[2];
    logic [2:0] m_lg[2];

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_now(input string tag, input int sel, input logic [2:0] y,
                             input logic v, input logic [7:0] p, input logic o);
        if (sel == 0) begin
            cmp({tag, ".Y"}, 8'(y_fp), 8'(y));
            cmp({tag, ".valid"}, 8'(v_fp), 8'(v));
            cmp({tag, ".pending"}, p_fp, p);
            cmp({tag, ".overflow"}, 8'(o_fp), 8'(o));
        end else begin
            cmp({tag, ".Y"}, 8'(y_rr), 8'(y));
            cmp({tag, ".valid"}, 8'(v_rr), 8'(v));
            cmp({tag, ".pending"}, p_rr, p);
            cmp({tag, ".overflow"}, 8'(o_rr), 8'(o));
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check_now(e.tag, e.sel, e.y, e.v, e.p, e.o);
        end
    endtask

    // Drive one vector before the edge, compare right after it.
    task automatic run_vec(input vec_t t, input string tag);
        exp_t e;
        @(negedge clk);
        A       = t.a;
        clr_all = t.clr;
        ready   = t.rdy;
        e.sel = t.sel; e.y = t.y; e.v = t.v; e.p = t.p; e.o = t.o; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; A = '0; clr_all = 1'b0; ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_now("reset_fp", 0, 3'd0, 1'b0, 8'h00, 1'b0);
        check_now("reset_rr", 1, 3'd0, 1'b0, 8'h00, 1'b0);
    endtask

    function automatic logic [2:0] model_pick(input int k, input logic [7:0] req, input logic [2:0] st);
        logic [2:0] r;
        logic [2:0] i;
        r = '0;
        if (k == 0) begin
            for (int j = 7; j >= 0; j--) begin
                if (req[j]) begin
                    r = 3'(j);
                    break;
                end
            end
        end else begin
            i = st;
            for (int j = 0; j < 8; j++) begin
                if (req[i]) begin
                    r = i;
                    break;
                end
                i = i + 3'd1;
            end
        end
        return r;
    endfunction

    task automatic model_step(input int k, input logic [7:0] a, input logic c, input logic r);
        logic       xf;
        logic [7:0] rem;
        logic [2:0] st;
        logic [2:0] old_y;
        xf    = m_v[k] && r;
        old_y = m_y[k];
        rem   = m_p[k];
        if (xf) rem[old_y] = 1'b0;
        st = xf ? old_y + 3'd1 : m_lg[k] + 3'd1;
        if (c) begin
            m_p[k] = '0;
            m_v[k] = 1'b0;
            m_o[k] = 1'b0;
        end else begin
            m_o[k] = |(a & rem);
            if (!m_v[k] || xf) begin
                if (rem != 8'h00) begin
                    m_v[k] = 1'b1;
                    m_y[k] = model_pick(k, rem, st);
                end else begin
                    m_v[k] = 1'b0;
                end
            end
            if (xf) m_lg[k] = old_y;
            m_p[k] = rem | a;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; A = '0; clr_all = 1'b0; ready = 1'b0;

        // a, clr, rdy, sel, Y, valid, pending, overflow (after the edge)
        fp_tab.push_back('{8'h04, 1'b0, 1'b1, 0, 3'd0, 1'b0, 8'h04, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd2, 1'b1, 8'h04, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd2, 1'b0, 8'h00, 1'b0});
        fp_tab.push_back('{8'hA5, 1'b0, 1'b1, 0, 3'd2, 1'b0, 8'hA5, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd7, 1'b1, 8'hA5, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd5, 1'b1, 8'h25, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd2, 1'b1, 8'h05, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd0, 1'b1, 8'h01, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd0, 1'b0, 8'h00, 1'b0});
        fp_tab.push_back('{8'h10, 1'b0, 1'b0, 0, 3'd0, 1'b0, 8'h10, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd4, 1'b1, 8'h10, 1'b0});
        fp_tab.push_back('{8'h90, 1'b0, 1'b0, 0, 3'd4, 1'b1, 8'h90, 1'b1});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd4, 1'b1, 8'h90, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd7, 1'b1, 8'h80, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd7, 1'b0, 8'h00, 1'b0});
        fp_tab.push_back('{8'h02, 1'b0, 1'b0, 0, 3'd7, 1'b0, 8'h02, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd1, 1'b1, 8'h02, 1'b0});
        fp_tab.push_back('{8'h02, 1'b0, 1'b1, 0, 3'd1, 1'b0, 8'h02, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd1, 1'b1, 8'h02, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd1, 1'b0, 8'h00, 1'b0});
        fp_tab.push_back('{8'h30, 1'b0, 1'b0, 0, 3'd1, 1'b0, 8'h30, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd5, 1'b1, 8'h30, 1'b0});
        fp_tab.push_back('{8'hFF, 1'b1, 1'b0, 0, 3'd5, 1'b0, 8'h00, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd5, 1'b0, 8'h00, 1'b0});
        fp_tab.push_back('{8'h0C, 1'b0, 1'b0, 0, 3'd5, 1'b0, 8'h0C, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b0, 0, 3'd3, 1'b1, 8'h0C, 1'b0});
        fp_tab.push_back('{8'h0C, 1'b0, 1'b1, 0, 3'd2, 1'b1, 8'h0C, 1'b1});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd3, 1'b1, 8'h08, 1'b0});
        fp_tab.push_back('{8'h00, 1'b0, 1'b1, 0, 3'd3, 1'b0, 8'h00, 1'b0});

        rr_tab.push_back('{8'h81, 1'b0, 1'b0, 1, 3'd0, 1'b0, 8'h81, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b0, 1, 3'd0, 1'b1, 8'h81, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b1, 1, 3'd7, 1'b1, 8'h80, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b1, 1, 3'd7, 1'b0, 8'h00, 1'b0});
        rr_tab.push_back('{8'h08, 1'b0, 1'b0, 1, 3'd7, 1'b0, 8'h08, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b0, 1, 3'd3, 1'b1, 8'h08, 1'b0});
        rr_tab.push_back('{8'h89, 1'b0, 1'b1, 1, 3'd3, 1'b0, 8'h89, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b1, 1, 3'd7, 1'b1, 8'h89, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b1, 1, 3'd0, 1'b1, 8'h09, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b1, 1, 3'd3, 1'b1, 8'h08, 1'b0});
        rr_tab.push_back('{8'h00, 1'b0, 1'b1, 1, 3'd3, 1'b0, 8'h00, 1'b0});

        do_reset();
        for (int i = 0; i < fp_tab.size(); i++) run_vec(fp_tab[i], $sformatf("fp[%0d]", i));

        do_reset();
        for (int i = 0; i < rr_tab.size(); i++) run_vec(rr_tab[i], $sformatf("rr[%0d]", i));

        // Asynchronous reset while presenting with an overflow pulse live.
        do_reset();
        run_vec('{8'h40, 1'b0, 1'b0, 0, 3'd0, 1'b0, 8'h40, 1'b0}, "ar_load");
        run_vec('{8'h40, 1'b0, 1'b0, 0, 3'd6, 1'b1, 8'h40, 1'b1}, "ar_present");
        #2;
        rst = 1'b1;
        #1;
        check_now("ar_async_fp", 0, 3'd0, 1'b0, 8'h00, 1'b0);
        check_now("ar_async_rr", 1, 3'd0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        A = 8'hFF; ready = 1'b1;
        @(posedge clk);
        #1;
        check_now("ar_held", 0, 3'd0, 1'b0, 8'h00, 1'b0);
        #1;
        rst = 1'b0;
        run_vec('{8'h02, 1'b0, 1'b0, 0, 3'd0, 1'b0, 8'h02, 1'b0}, "ar_first_edge");
        run_vec('{8'h00, 1'b0, 1'b0, 0, 3'd1, 1'b1, 8'h02, 1'b0}, "ar_present2");
        run_vec('{8'h00, 1'b0, 1'b1, 0, 3'd1, 1'b0, 8'h00, 1'b0}, "ar_drain");

        // Random traffic against the reference model, both instances.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0; m_y[k] = '0; m_p[k] = '0; m_o[k] = 1'b0; m_lg[k] = 3'd7;
        end
        for (int n = 0; n < 400; n++) begin
            logic [7:0] ra;
            logic       rc;
            logic       rr;
            exp_t       e;
            ra = ($urandom_range(0, 2) == 0) ? 8'($urandom) :
                 (($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00);
            rc = ($urandom_range(0, 31) == 0);
            rr = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            A = ra; clr_all = rc; ready = rr;
            for (int k = 0; k < 2; k++) begin
                model_step(k, ra, rc, rr);
                e.sel = k; e.y = m_y[k]; e.v = m_v[k]; e.p = m_p[k]; e.o = m_o[k];
                e.tag = $sformatf("rand%0d[%0d]", k, n);
                sb.push_back(e);
            end
            @(posedge clk);
            #1;
            pop_check();
            pop_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
